// File: rtl/cmd_sequencer.sv
// Command sequencer: walks a command index FIRST_CMD..LAST_CMD with a start strobe, a two-phase
// ready_command handshake and an inter-command gap. Define CMD_SEQ_TIMEOUT_EN for the handshake watchdog.
module cmd_sequencer #(
    parameter int CMD_W       = 3,
    parameter int DELAY_W     = 25,
    parameter int DELAY       = 5,
    parameter int FIRST_CMD   = 0,
    parameter int LAST_CMD    = 7,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             loop_mode,
    input  logic             abort,
    input  logic             ready_command,
    output logic [CMD_W-1:0] command,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [2:0]       dbg_state
);

    // Handshake: start is a one-cycle strobe with command already stable; the slave accepts by
    // driving ready_command low, and completes by driving it high again. No other meaning is assumed.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_ACK_WAIT  = 3'd2,
        ST_DONE_WAIT = 3'd3,
        ST_GAP       = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    localparam logic [CMD_W-1:0]   FIRST    = CMD_W'(FIRST_CMD);
    localparam logic [CMD_W-1:0]   LAST     = CMD_W'(LAST_CMD);
    localparam logic [DELAY_W-1:0] GAP_LOAD = DELAY_W'(DELAY - 1);

    if (DELAY < 1 || FIRST_CMD < 0 || FIRST_CMD > LAST_CMD ||
        LAST_CMD > (2 ** CMD_W) - 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("cmd_sequencer: illegal parameter set");
    end

    state_t             state, state_n;
    logic [CMD_W-1:0]   cmd_n;
    logic [DELAY_W-1:0] dly_cnt, dly_n;
    logic               hs_timeout;

    assign dbg_state = state;

`ifdef CMD_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt, wd_n;
    logic            err_n;

    assign hs_timeout = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
            error  <= 1'b0;
        end else begin
            wd_cnt <= wd_n;
            error  <= err_n;
        end
    end
`else
    assign hs_timeout = 1'b0;
    assign error      = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cmd_n   = command;
        dly_n   = dly_cnt;
`ifdef CMD_SEQ_TIMEOUT_EN
        err_n   = error;
        wd_n    = wd_cnt;
        if (state == ST_ACK_WAIT || state == ST_DONE_WAIT) begin
            wd_n = wd_cnt + WD_W'(1);
        end
`endif
        case (state)
            ST_IDLE: begin
                if (enable) state_n = ST_SEND;
            end
            ST_SEND: begin
                state_n = ST_ACK_WAIT;
`ifdef CMD_SEQ_TIMEOUT_EN
                wd_n    = '0;
`endif
            end
            ST_ACK_WAIT: begin
                if (hs_timeout) begin
                    state_n = ST_FINISH;
`ifdef CMD_SEQ_TIMEOUT_EN
                    err_n   = 1'b1;
`endif
                end else if (!ready_command) begin
                    state_n = ST_DONE_WAIT;
                end
            end
            ST_DONE_WAIT: begin
                // Completion on the last watchdog cycle still counts as a good handshake.
                if (ready_command) begin
                    state_n = ST_GAP;
                    dly_n   = GAP_LOAD;
                end else if (hs_timeout) begin
                    state_n = ST_FINISH;
`ifdef CMD_SEQ_TIMEOUT_EN
                    err_n   = 1'b1;
`endif
                end
            end
            ST_GAP: begin
                if (dly_cnt == '0) begin
                    if (command != LAST) begin
                        cmd_n   = command + CMD_W'(1);
                        state_n = ST_SEND;
                    end else if (loop_mode) begin
                        cmd_n   = FIRST;
                        state_n = ST_SEND;
                    end else begin
                        state_n = ST_FINISH;
                    end
                end else begin
                    dly_n = dly_cnt - DELAY_W'(1);
                end
            end
            ST_FINISH: begin
                if (!enable) begin
                    state_n = ST_IDLE;
                    cmd_n   = FIRST;
`ifdef CMD_SEQ_TIMEOUT_EN
                    err_n   = 1'b0;
`endif
                end
            end
            default: begin
                state_n = ST_IDLE;
                cmd_n   = FIRST;
            end
        endcase

        if (abort) begin
            state_n = ST_IDLE;
            cmd_n   = FIRST;
            dly_n   = '0;
`ifdef CMD_SEQ_TIMEOUT_EN
            wd_n    = '0;
            err_n   = 1'b0;
`endif
        end
    end

    // Outputs are registered decodes of the next state, so they move together with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            command <= FIRST;
            start   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dly_cnt <= '0;
        end else begin
            state   <= state_n;
            command <= cmd_n;
            start   <= (state_n == ST_SEND);
            busy    <= (state_n != ST_IDLE) && (state_n != ST_FINISH);
            done    <= (state_n == ST_FINISH);
            dly_cnt <= dly_n;
        end
    end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: two instances (default range/gap, and range 2..4 with a one-cycle gap)
// checked every cycle against a behavioural model, plus directed scenarios with literal expectations.
module tb_cmd_sequencer;

    localparam int CMD_W   = 3;
    localparam int DELAY_W = 25;
    localparam int TO      = 16;

    localparam int PH_IDLE = 0, PH_SEND = 1, PH_ACK = 2, PH_DONE = 3, PH_GAP = 4, PH_FIN = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0, loop_mode = 1'b0, abort = 1'b0;
    logic [1:0] rdy = 2'b11;
    logic [CMD_W-1:0] cmd_a, cmd_b;
    logic start_a, start_b, busy_a, busy_b, done_a, done_b, error_a, error_b;
    logic [2:0] dbg_a, dbg_b;

    cmd_sequencer #(.CMD_W(CMD_W), .DELAY_W(DELAY_W), .DELAY(5), .FIRST_CMD(0), .LAST_CMD(7),
                    .TIMEOUT_CYC(TO)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .loop_mode(loop_mode), .abort(abort),
        .ready_command(rdy[0]), .command(cmd_a), .start(start_a), .busy(busy_a), .done(done_a),
        .error(error_a), .dbg_state(dbg_a));

    cmd_sequencer #(.CMD_W(CMD_W), .DELAY_W(DELAY_W), .DELAY(1), .FIRST_CMD(2), .LAST_CMD(4),
                    .TIMEOUT_CYC(TO)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .loop_mode(loop_mode), .abort(abort),
        .ready_command(rdy[1]), .command(cmd_b), .start(start_b), .busy(busy_b), .done(done_b),
        .error(error_b), .dbg_state(dbg_b));

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, cyc = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_ph[2], m_cmd[2], m_gap[2], m_wd[2], m_err[2];

    function automatic int p_first(input int i); return (i == 0) ? 0 : 2; endfunction
    function automatic int p_last(input int i);  return (i == 0) ? 7 : 4; endfunction
    function automatic int p_delay(input int i); return (i == 0) ? 5 : 1; endfunction

    function automatic bit wd_expired(input int i);
`ifdef CMD_SEQ_TIMEOUT_EN
        return m_wd[i] >= TO - 1;
`else
        return (i < 0);
`endif
    endfunction

    task automatic model_reset(input int i);
        m_ph[i] = PH_IDLE; m_cmd[i] = p_first(i); m_gap[i] = 0; m_wd[i] = 0; m_err[i] = 0;
    endtask

    task automatic model_step(input int i, input logic r);
        if (abort) begin
            model_reset(i);
            return;
        end
        case (m_ph[i])
            PH_IDLE: if (enable) m_ph[i] = PH_SEND;
            PH_SEND: begin m_ph[i] = PH_ACK; m_wd[i] = 0; end
            PH_ACK: begin
                if (wd_expired(i)) begin m_ph[i] = PH_FIN; m_err[i] = 1; end
                else if (!r) m_ph[i] = PH_DONE;
                m_wd[i]++;
            end
            PH_DONE: begin
                if (r) begin m_ph[i] = PH_GAP; m_gap[i] = p_delay(i); end
                else if (wd_expired(i)) begin m_ph[i] = PH_FIN; m_err[i] = 1; end
                m_wd[i]++;
            end
            PH_GAP: begin
                m_gap[i]--;
                if (m_gap[i] == 0) begin
                    if (m_cmd[i] != p_last(i)) begin m_cmd[i]++; m_ph[i] = PH_SEND; end
                    else if (loop_mode) begin m_cmd[i] = p_first(i); m_ph[i] = PH_SEND; end
                    else m_ph[i] = PH_FIN;
                end
            end
            default: if (!enable) begin m_ph[i] = PH_IDLE; m_cmd[i] = p_first(i); m_err[i] = 0; end
        endcase
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                model_reset(0);
                model_reset(1);
            end else begin
                cyc++;
                model_step(0, rdy[0]);
                model_step(1, rdy[1]);
            end
        end
    end

    // ---------------- slave model (stimulus) ----------------
    int s_pre[2], s_low[2];
    int sl_lat = 1, sl_len = 2;
    bit slave_never = 1'b0;

    task automatic slave_step(input int i, input logic s);
        if (!rst || slave_never) begin
            s_pre[i] = 0; s_low[i] = 0; rdy[i] = 1'b1;
            return;
        end
        if (s) begin s_pre[i] = sl_lat; s_low[i] = sl_len; end
        if (s_pre[i] > 0) begin s_pre[i]--; rdy[i] = 1'b1; end
        else if (s_low[i] > 0) begin s_low[i]--; rdy[i] = 1'b0; end
        else rdy[i] = 1'b1;
    endtask

    initial begin
        s_pre = '{0, 0};
        s_low = '{0, 0};
        forever begin
            @(negedge clk);
            slave_step(0, start_a);
            slave_step(1, start_b);
        end
    end

    // ---------------- compare process and start logs ----------------
    int la_c[$], la_t[$], lb_c[$], lb_t[$];
    int dn_a = 0, dn_b = 0;
    logic [CMD_W-1:0] exp_q[$];

    task automatic cmp_dut(input int i, input logic [CMD_W-1:0] c, input logic s, input logic b,
                           input logic d, input logic e);
        string tag = (i == 0) ? "A" : "B";
        int ph = m_ph[i];
        check({tag, ".command"}, int'(c), m_cmd[i]);
        check({tag, ".start"}, int'(s), int'(ph == PH_SEND));
        check({tag, ".busy"}, int'(b), int'(ph != PH_IDLE && ph != PH_FIN));
        check({tag, ".done"}, int'(d), int'(ph == PH_FIN));
        check({tag, ".error"}, int'(e), m_err[i]);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                cmp_dut(0, cmd_a, start_a, busy_a, done_a, error_a);
                cmp_dut(1, cmd_b, start_b, busy_b, done_b, error_b);
            end
            if (start_a) begin la_c.push_back(int'(cmd_a)); la_t.push_back(cyc); end
            if (start_b) begin lb_c.push_back(int'(cmd_b)); lb_t.push_back(cyc); end
            if (done_a) dn_a++;
            if (done_b) dn_b++;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    function automatic bit hit(input int i, input int what, input int want);
        logic s = (i == 0) ? start_a : start_b;
        logic d = (i == 0) ? done_a : done_b;
        int c = (i == 0) ? int'(cmd_a) : int'(cmd_b);
        if (what == 1) return d;
        return s && (want < 0 || c == want);
    endfunction

    task automatic wait_for(input int i, input int what, input int want, input int budget,
                            input string name);
        int n = 0;
        while (!hit(i, what, want) && n < budget) begin
            tick();
            n++;
        end
        check({name, " reached"}, int'(hit(i, what, want)), 1);
    endtask

    task automatic clear_logs();
        la_c.delete(); la_t.delete(); lb_c.delete(); lb_t.delete();
        dn_a = 0; dn_b = 0;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int n;
        ticks(3);
        check("reset A.command", int'(cmd_a), 0);
        check("reset B.command", int'(cmd_b), 2);
        check("reset start", int'({start_a, start_b}), 0);
        check("reset busy", int'({busy_a, busy_b}), 0);
        check("reset done", int'({done_a, done_b}), 0);
        check("reset error", int'({error_a, error_b}), 0);
        rst = 1'b1;
        chk_on = 1'b1;
        tick();

        // One-shot run over the full range, slave busy for two cycles.
        clear_logs();
        sl_lat = 1; sl_len = 2;
        enable = 1'b1;
        wait_for(0, 1, -1, 200, "oneshot A done");
        for (int k = 0; k <= 7; k++) exp_q.push_back(CMD_W'(k));
        check("oneshot A pulses", la_c.size(), 8);
        for (int k = 0; k < la_c.size() && exp_q.size() > 0; k++) begin
            check("oneshot A order", la_c[k], int'(exp_q.pop_front()));
            if (k > 0) check("oneshot A spacing", la_t[k] - la_t[k-1], 9);
        end
        exp_q.delete();
        check("oneshot A final cmd", int'(cmd_a), 7);
        check("oneshot B pulses", lb_c.size(), 3);
        for (int k = 0; k < lb_c.size(); k++) begin
            check("oneshot B order", lb_c[k], 2 + k);
            if (k > 0) check("oneshot B spacing", lb_t[k] - lb_t[k-1], 5);
        end
        ticks(5);
        check("finish holds done", int'(done_a), 1);
        check("no auto restart", la_c.size(), 8);
        enable = 1'b0;
        tick();
        check("finish exit done", int'(done_a), 0);
        check("finish exit A.command", int'(cmd_a), 0);
        check("finish exit B.command", int'(cmd_b), 2);

        // Looping, then leave loop mode during the last index.
        clear_logs();
        sl_lat = 2; sl_len = 1;
        loop_mode = 1'b1;
        enable = 1'b1;
        n = 0;
        while (lb_c.size() < 7 && n < 100) begin tick(); n++; end
        check("loop B pulses", int'(lb_c.size() >= 7), 1);
        for (int k = 0; k < 7 && k < lb_c.size(); k++) check("loop B order", lb_c[k], 2 + (k % 3));
        check("loop no done", dn_a + dn_b, 0);
        wait_for(1, 0, 4, 30, "loop B at last cmd");
        loop_mode = 1'b0;
        wait_for(1, 1, -1, 40, "loop B done");
        check("loop B stop cmd", int'(cmd_b), 4);
        check("loop B last pulse", (lb_c.size() > 0) ? lb_c[lb_c.size()-1] : -1, 4);
        wait_for(0, 1, -1, 200, "loop A done");
        check("loop A stop cmd", int'(cmd_a), 7);
        enable = 1'b0;
        tick();

        // Abort in the middle of the gap after command 3.
        sl_lat = 1; sl_len = 2;
        enable = 1'b1;
        wait_for(0, 0, 3, 60, "abort A at cmd 3");
        enable = 1'b0;
        ticks(5);
        n = la_c.size();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort gap busy", int'(busy_a), 0);
        check("abort gap command", int'(cmd_a), 0);
        check("abort gap start", int'(start_a), 0);
        ticks(4);
        check("abort gap no pulse", la_c.size(), n);

        // Abort on the final gap cycle beats the advance.
        enable = 1'b1;
        wait_for(0, 0, 0, 5, "abort A at cmd 0");
        enable = 1'b0;
        ticks(8);
        n = la_c.size();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort expiry start", int'(start_a), 0);
        check("abort expiry busy", int'(busy_a), 0);
        check("abort expiry command", int'(cmd_a), 0);
        ticks(3);
        check("abort expiry no pulse", la_c.size(), n);

        // Slave never acknowledges.
        clear_logs();
        slave_never = 1'b1;
        enable = 1'b1;
        ticks(25);
        check("stuck A pulses", la_c.size(), 1);
`ifdef CMD_SEQ_TIMEOUT_EN
        check("timeout error", int'(error_a), 1);
        check("timeout done", int'(done_a), 1);
        check("timeout command", int'(cmd_a), 0);
`else
        check("stuck busy", int'(busy_a), 1);
        check("stuck error", int'(error_a), 0);
`endif
        abort = 1'b1;
        enable = 1'b0;
        tick();
        abort = 1'b0;
        slave_never = 1'b0;
        tick();

        // Asynchronous reset while waiting for completion.
        sl_lat = 1; sl_len = 4;
        enable = 1'b1;
        wait_for(0, 0, 0, 5, "reset test start");
        ticks(3);
        #2 rst = 1'b0;
        #1;
        check("async rst start", int'(start_a), 0);
        check("async rst busy", int'(busy_a), 0);
        check("async rst done", int'(done_a), 0);
        check("async rst error", int'(error_a), 0);
        check("async rst B.command", int'(cmd_b), 2);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post rst start", int'(start_a), 1);
        check("post rst command", int'(cmd_a), 0);
        abort = 1'b1;
        enable = 1'b0;
        tick();
        abort = 1'b0;

        // One-cycle gap with ready already low on ACK_WAIT entry.
        clear_logs();
        sl_lat = 0; sl_len = 2;
        enable = 1'b1;
        wait_for(1, 1, -1, 60, "short gap B done");
        check("short gap B pulses", lb_c.size(), 3);
        for (int k = 1; k < lb_c.size(); k++) check("short gap B spacing", lb_t[k] - lb_t[k-1], 4);
        enable = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Random traffic against the model.
        for (int k = 0; k < 500; k++) begin
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) loop_mode = $urandom_range(0, 1);
            abort = ($urandom_range(0, 40) == 0);
            sl_lat = $urandom_range(0, 3);
            sl_len = (sl_lat == 0) ? $urandom_range(2, 4) : $urandom_range(1, 4);
            tick();
        end
        abort = 1'b0;
        enable = 1'b0;
        ticks(2);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
